// File: rtl/bp_update_unit_pkg.sv
// Shared constants for the branch-predictor update path: table geometry,
// 2-bit PHT counter encodings and update FSM state codes.
package bp_update_unit_pkg;

  localparam int BTB_LEN  = 64;
  localparam int BTB_BITS = $clog2(BTB_LEN);
  localparam int GHR_LEN  = 256;
  localparam int GHR_BITS = $clog2(GHR_LEN);

  localparam logic [1:0] PHT_SNT = 2'b00;
  localparam logic [1:0] PHT_WNT = 2'b01;
  localparam logic [1:0] PHT_WT  = 2'b10;
  localparam logic [1:0] PHT_ST  = 2'b11;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_UPD  = 1'b1;

endpackage

// File: rtl/bp_update_unit_if.sv
// Bundle of EX update requests and BTB/PHT write-side ports. The master side
// is the surrounding core (EX stage plus predictor tables); the slave is the unit.
interface bp_update_unit_if #(
  parameter int BTB_IDX_W = 6,
  parameter int GHR_W     = 8
);
  logic                 ex_valid;
  logic                 ex_btb_wen;
  logic [BTB_IDX_W-1:0] ex_btb_windex;
  logic [31:0]          ex_btb_wtarget;
  logic                 ex_gshare_wen;
  logic [GHR_W-1:0]     ex_gshare_windex;
  logic                 ex_taken;
  logic                 btb_we;
  logic [BTB_IDX_W-1:0] btb_waddr;
  logic [31:0]          btb_wdata;
  logic [GHR_W-1:0]     pht_raddr;
  logic [1:0]           pht_rdata;
  logic                 pht_we;
  logic [GHR_W-1:0]     pht_waddr;
  logic [1:0]           pht_wdata;
  logic                 busy;
  logic [15:0]          drop_cnt;

  modport master (
    output ex_valid, ex_btb_wen, ex_btb_windex, ex_btb_wtarget,
           ex_gshare_wen, ex_gshare_windex, ex_taken, pht_rdata,
    input  btb_we, btb_waddr, btb_wdata, pht_raddr, pht_we, pht_waddr,
           pht_wdata, busy, drop_cnt
  );

  modport slave (
    input  ex_valid, ex_btb_wen, ex_btb_windex, ex_btb_wtarget,
           ex_gshare_wen, ex_gshare_windex, ex_taken, pht_rdata,
    output btb_we, btb_waddr, btb_wdata, pht_raddr, pht_we, pht_waddr,
           pht_wdata, busy, drop_cnt
  );
endinterface

// File: rtl/bp_upd_fifo.sv
// Generic DEPTH x W synchronous FIFO. A push while full is accepted only when
// a pop happens in the same cycle; otherwise it is silently refused.
module bp_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/bp_update_unit.sv
// Branch-predictor update unit: queues resolved-branch updates from EX and
// drains them into the BTB write port and the PHT read-modify-write port.
module bp_update_unit
  import bp_update_unit_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int BTB_IDX_W = BTB_BITS,
  parameter int GHR_W     = GHR_BITS
) (
  input  logic             clk,
  input  logic             resetn,
  bp_update_unit_if.slave  bus
);

  localparam int EW = BTB_IDX_W + GHR_W + 35;
  localparam int CW = $clog2(DEPTH + 1);

  function automatic logic [1:0] pht_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    case (ctr)
      PHT_SNT: nxt = taken ? PHT_WNT : PHT_SNT;
      PHT_WNT: nxt = taken ? PHT_WT  : PHT_SNT;
      PHT_WT:  nxt = taken ? PHT_ST  : PHT_WNT;
      default: nxt = taken ? PHT_ST  : PHT_WT;
    endcase
    return nxt;
  endfunction

  logic                 req, pop, full, empty;
  logic [EW-1:0]        push_data, head;
  logic [CW-1:0]        count;
  logic                 h_btb_wen, h_gs_wen, h_taken;
  logic [BTB_IDX_W-1:0] h_btb_idx;
  logic [31:0]          h_target;
  logic [GHR_W-1:0]     h_gs_idx;

  logic [0:0]           state_q, state_d;
  logic                 btb_we_q, btb_we_d, pht_we_q, pht_we_d;
  logic [BTB_IDX_W-1:0] btb_waddr_q, btb_waddr_d;
  logic [31:0]          btb_wdata_q, btb_wdata_d;
  logic [GHR_W-1:0]     pht_raddr_q, pht_raddr_d, pht_waddr_q, pht_waddr_d;
  logic [1:0]           pht_wdata_q, pht_wdata_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;

  // Requests carrying neither a BTB write nor PHT training are not hints at all.
  assign req       = bus.ex_valid && (bus.ex_btb_wen || bus.ex_gshare_wen);
  assign push_data = {bus.ex_btb_wen, bus.ex_btb_windex, bus.ex_btb_wtarget,
                      bus.ex_gshare_wen, bus.ex_gshare_windex, bus.ex_taken};
  assign {h_btb_wen, h_btb_idx, h_target, h_gs_wen, h_gs_idx, h_taken} = head;

  bp_upd_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (req),
    .push_data (push_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    btb_we_d    = 1'b0;
    pht_we_d    = 1'b0;
    btb_waddr_d = btb_waddr_q;
    btb_wdata_d = btb_wdata_q;
    pht_raddr_d = pht_raddr_q;
    pht_waddr_d = pht_waddr_q;
    pht_wdata_d = pht_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          if (!h_gs_wen) begin
            btb_we_d    = h_btb_wen;
            btb_waddr_d = h_btb_idx;
            btb_wdata_d = h_target;
            pop         = 1'b1;
          end else begin
            pht_raddr_d = h_gs_idx;
            state_d     = ST_UPD;
          end
        end
      end
      ST_UPD: begin
        pht_we_d    = 1'b1;
        pht_waddr_d = h_gs_idx;
        pht_wdata_d = pht_next(bus.pht_rdata, h_taken);
        if (h_btb_wen) begin
          btb_we_d    = 1'b1;
          btb_waddr_d = h_btb_idx;
          btb_wdata_d = h_target;
        end
        pop     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    drop_cnt_d = drop_cnt_q;
    if (req && full && !pop && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      btb_we_q    <= 1'b0;
      pht_we_q    <= 1'b0;
      btb_waddr_q <= '0;
      btb_wdata_q <= '0;
      pht_raddr_q <= '0;
      pht_waddr_q <= '0;
      pht_wdata_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      btb_we_q    <= btb_we_d;
      pht_we_q    <= pht_we_d;
      btb_waddr_q <= btb_waddr_d;
      btb_wdata_q <= btb_wdata_d;
      pht_raddr_q <= pht_raddr_d;
      pht_waddr_q <= pht_waddr_d;
      pht_wdata_q <= pht_wdata_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // The read address leaves in the IDLE decision cycle so the synchronous PHT
  // returns the counter exactly when the FSM sits in UPD.
  assign bus.pht_raddr = pht_raddr_d;
  assign bus.btb_we    = btb_we_q;
  assign bus.btb_waddr = btb_waddr_q;
  assign bus.btb_wdata = btb_wdata_q;
  assign bus.pht_we    = pht_we_q;
  assign bus.pht_waddr = pht_waddr_q;
  assign bus.pht_wdata = pht_wdata_q;
  assign bus.drop_cnt  = drop_cnt_q;
  assign bus.busy      = (count != '0) || (state_q != ST_IDLE);

endmodule
